// File: rtl/fft_bitrev_loader.sv
// fft_bitrev_loader -- bit-reversal input stage ahead of butterfly_sum.
//
// Accepts a frame of N = 2**N_LOG2 packed complex samples in natural order.
// Each sample is written to the bit-reversed address of its arrival index.
// The frame is then drained as N/2 first-stage butterfly operand pairs
// (mem[2k], mem[2k+1]). Every pair carries the stage-1 twiddles (+1, -1),
// so butterfly_sum produces A+B and A-B directly. FILL and DRAIN never
// overlap, so one frame takes N + N/2 cycles.
//
// Optional build macro BITREV_SCALE_EN: each component is arithmetically
// shifted right by one before it is stored (1/2 input scaling). Without the
// macro, samples are stored bit-exact. Handshake and timing are the same in
// both builds.
//
// Ports:
//   i_CLK       clock, rising edge
//   i_RST       asynchronous reset, active low
//   i_valid     upstream sample valid
//   o_ready     loader can accept a sample (FILL, out of reset)
//   i_sample    packed complex sample {real, imag}
//   o_valid     operand pair valid (DRAIN)
//   i_ready     downstream accepts the pair
//   o_A, o_B    operands mem[2k], mem[2k+1] (0 when o_valid is low)
//   o_twiddleA  {TW_ONE, 0} while o_valid, else 0
//   o_twiddleB  {-TW_ONE, 0} while o_valid, else 0
//   o_last      final pair of the frame
module fft_bitrev_loader #(
  parameter int N_LOG2   = 3,
  parameter int WORD_SZ  = 32,
  parameter int WORD_MID = 16,
  parameter int TW_ONE   = 64
) (
  input  logic               i_CLK,
  input  logic               i_RST,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [WORD_SZ-1:0] i_sample,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [WORD_SZ-1:0] o_A,
  output logic [WORD_SZ-1:0] o_B,
  output logic [WORD_SZ-1:0] o_twiddleA,
  output logic [WORD_SZ-1:0] o_twiddleB,
  output logic               o_last
);

  localparam int N    = 1 << N_LOG2;
  // With N_LOG2 = 1 there is a single pair; keep a 1-bit counter pinned at 0.
  localparam int RD_W = (N_LOG2 > 1) ? N_LOG2 - 1 : 1;
  localparam int TW_W = WORD_SZ - WORD_MID;

  localparam logic [TW_W-1:0] TW_POS = TW_W'(TW_ONE);
  localparam logic [TW_W-1:0] TW_NEG = TW_W'(-TW_ONE);

  localparam logic [0:0] FILL  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]                  state;
  logic                        live;     // low until the first edge after reset
  logic [N_LOG2-1:0]           wr_cnt;
  logic [RD_W-1:0]             rd_cnt;
  logic [N-1:0][WORD_SZ-1:0]   mem;
  logic [WORD_SZ-1:0]          wdata;
  logic [N_LOG2-1:0]           a_idx, b_idx;
  logic                        wr_en, rd_fire, last_pair;

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] x);
    logic [N_LOG2-1:0] r;
    for (int i = 0; i < N_LOG2; i++) r[i] = x[N_LOG2-1-i];
    return r;
  endfunction

`ifdef BITREV_SCALE_EN
  // Sign-extending shift per component; the dropped LSBs are intentionally lost.
  assign wdata = {i_sample[WORD_SZ-1],  i_sample[WORD_SZ-1:WORD_MID+1],
                  i_sample[WORD_MID-1], i_sample[WORD_MID-1:1]};
  logic unused_lsbs;
  assign unused_lsbs = i_sample[WORD_MID] ^ i_sample[0];
`else
  assign wdata = i_sample;
`endif

  assign o_ready   = live && (state == FILL);
  assign o_valid   = (state == DRAIN);
  assign wr_en     = i_valid && o_ready;
  assign rd_fire   = o_valid && i_ready;
  assign last_pair = (rd_cnt == RD_W'(N/2 - 1));

  // Pair k lives at addresses 2k and 2k+1; the cast drops the counter's
  // unused bit when N_LOG2 = 1.
  assign a_idx = N_LOG2'({rd_cnt, 1'b0});
  assign b_idx = a_idx | N_LOG2'(1);

  assign o_A        = o_valid ? mem[a_idx] : '0;
  assign o_B        = o_valid ? mem[b_idx] : '0;
  assign o_twiddleA = o_valid ? {TW_POS, {WORD_MID{1'b0}}} : '0;
  assign o_twiddleB = o_valid ? {TW_NEG, {WORD_MID{1'b0}}} : '0;
  assign o_last     = o_valid && last_pair;

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state  <= FILL;
      live   <= 1'b0;
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      live <= 1'b1;
      case (state)
        FILL: begin
          if (wr_en) begin
            wr_cnt <= wr_cnt + 1'b1;  // wraps to 0 after N-1
            if (wr_cnt == N_LOG2'(N - 1)) state <= DRAIN;
          end
        end
        default: begin
          if (rd_fire) begin
            if (last_pair) begin
              rd_cnt <= '0;
              state  <= FILL;
            end else begin
              rd_cnt <= rd_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) mem <= '0;
    else if (wr_en) mem[bitrev(wr_cnt)] <= wdata;
  end

endmodule

// File: tb/tb_fft_bitrev_loader.sv
module tb_fft_bitrev_loader;
  localparam int N_LOG2 = 3;
  localparam int N      = 1 << N_LOG2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, i_ready, o_ready, o_valid, o_last;
  logic [31:0] i_sample, o_A, o_B, o_twiddleA, o_twiddleB;

  int checks = 0;
  int errors = 0;

  logic [31:0] cur [N];
  bit          first_chk;
  logic [31:0] first_a, first_b;

  fft_bitrev_loader #(.N_LOG2(N_LOG2)) dut (
    .i_CLK(clk), .i_RST(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_sample(i_sample), .o_valid(o_valid), .i_ready(i_ready),
    .o_A(o_A), .o_B(o_B), .o_twiddleA(o_twiddleA), .o_twiddleB(o_twiddleB),
    .o_last(o_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: sample j of a frame lands at the address whose bits are
  // j reversed, so address a holds sample rev(a).
  function automatic int rev(input int x);
    int r = 0;
    int v = x;
    for (int i = 0; i < N_LOG2; i++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  function automatic logic [31:0] scl(input logic [31:0] s);
`ifdef BITREV_SCALE_EN
    logic signed [15:0] re, im;
    re = s[31:16];
    im = s[15:0];
    re = re >>> 1;
    im = im >>> 1;
    return {re, im};
`else
    return s;
`endif
  endfunction

  function automatic logic [31:0] exp_mem(input int addr);
    return scl(cur[rev(addr)]);
  endfunction

  task automatic rand_frame();
    for (int i = 0; i < N; i++) cur[i] = $urandom;
  endtask

  task automatic fill(input int cnt, input bit stall);
    int i = 0;
    int cyc = 0;
    bit v;
    while (i < cnt) begin
      @(negedge clk);
      cyc++;
      if (cyc > 8 * N) begin
        errors++;
        $error("FAIL fill_timeout: observed %0d accepted required %0d", i, cnt);
        break;
      end
      chk("fill_ready", o_ready, 1);
      chk("fill_valid", o_valid, 0);
      chk("fill_A_gated", o_A, 0);
      chk("fill_twB_gated", o_twiddleB, 0);
      v = !stall || (cyc % 2 == 1);
      i_valid  = v;
      i_sample = v ? cur[i] : $urandom;
      @(posedge clk);
      if (v) i++;
    end
  endtask

  task automatic drain(input int npairs, input int stall_k);
    for (int k = 0; k < npairs; k++) begin
      @(negedge clk);
      chk("pair_valid", o_valid, 1);
      chk("pair_ready", o_ready, 0);
      chk("pair_A", o_A, exp_mem(2 * k));
      chk("pair_B", o_B, exp_mem(2 * k + 1));
      chk("pair_twA", o_twiddleA, 32'h0040_0000);
      chk("pair_twB", o_twiddleB, 32'hFFC0_0000);
      chk("pair_last", o_last, (k == N / 2 - 1));
      if (k == 0 && first_chk) begin
        chk("first_A_const", o_A, first_a);
        chk("first_B_const", o_B, first_b);
        first_chk = 0;
      end
      // Keep offering data while draining; it must be ignored.
      i_valid  = 1;
      i_sample = $urandom;
      if (k == stall_k) begin
        i_ready = 0;
        repeat (5) begin
          @(posedge clk);
          @(negedge clk);
          chk("hold_valid", o_valid, 1);
          chk("hold_ready", o_ready, 0);
          chk("hold_A", o_A, exp_mem(2 * k));
          chk("hold_B", o_B, exp_mem(2 * k + 1));
          chk("hold_twA", o_twiddleA, 32'h0040_0000);
          chk("hold_last", o_last, (k == N / 2 - 1));
        end
        i_ready = 1;
      end
      @(posedge clk);
    end
    if (npairs == N / 2) begin
      @(negedge clk);
      i_valid = 0;
      chk("post_ready", o_ready, 1);
      chk("post_valid", o_valid, 0);
      chk("post_A_gated", o_A, 0);
      chk("post_twA_gated", o_twiddleA, 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 0;
    i_valid = 1;
    i_sample = $urandom;
    #1;
    chk("rst_async_ready", o_ready, 0);
    chk("rst_async_valid", o_valid, 0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", o_ready, 0);
      chk("rst_valid", o_valid, 0);
      chk("rst_A", o_A, 0);
      chk("rst_B", o_B, 0);
      chk("rst_twA", o_twiddleA, 0);
      chk("rst_twB", o_twiddleB, 0);
      chk("rst_last", o_last, 0);
    end
    i_valid = 0;
    rst_n   = 1;
    @(negedge clk);
    chk("rel_ready", o_ready, 1);
    chk("rel_valid", o_valid, 0);
  endtask

  task automatic idle_no_valid(input int n);
    i_valid = 0;
    repeat (n) begin
      @(negedge clk);
      chk("idle_no_valid", o_valid, 0);
      chk("idle_ready", o_ready, 1);
    end
  endtask

  initial begin
    rst_n = 0; i_valid = 0; i_ready = 1; i_sample = '0; first_chk = 0;
    first_a = '0; first_b = '0;

    // Reset with i_valid high, then release.
    do_reset();

    // Directed frame: sample k = {16k, -k}.
    for (int k = 0; k < N; k++) cur[k] = {16'(16 * k), 16'(-k)};
    first_chk = 1;
    first_a   = 32'h0000_0000;
`ifdef BITREV_SCALE_EN
    first_b   = 32'h0020_FFFE;
`else
    first_b   = 32'h0040_FFFC;
`endif
    fill(N, 0);
    drain(N / 2, -1);

    // Same frame, backpressure on pair index 1, i.e. operands (2,6).
    fill(N, 0);
    drain(N / 2, 1);

    // Random frames with input stalls, then back-to-back frames.
    rand_frame();
    fill(N, 1);
    drain(N / 2, -1);
    rand_frame();
    fill(N, 0);
    drain(N / 2, 2);

    // Reset after 5 samples; nothing may be emitted, then a clean frame.
    rand_frame();
    fill(5, 0);
    do_reset();
    idle_no_valid(4);
    rand_frame();
    fill(N, 0);
    drain(N / 2, -1);

    // Reset after 2 drained pairs.
    rand_frame();
    fill(N, 0);
    drain(2, -1);
    do_reset();
    idle_no_valid(4);
    rand_frame();
    fill(N, 1);
    drain(N / 2, 3);

    // Scaling corner: sample 0 = 0x7FFF_FFFD.
    rand_frame();
    cur[0]    = 32'h7FFF_FFFD;
    first_chk = 1;
`ifdef BITREV_SCALE_EN
    first_a   = 32'h3FFF_FFFE;
`else
    first_a   = 32'h7FFF_FFFD;
`endif
    first_b   = scl(cur[rev(1)]);
    fill(N, 0);
    drain(N / 2, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed time limit reached, required finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fft_bitrev_loader.md
Name: fft_bitrev_loader

Overview:
- Input stage directly upstream of butterfly_sum.
- Accepts a frame of N complex samples in natural order over a valid/ready stream.
- Stores each sample at its bit-reversed address, then drains the frame as N/2 first-stage butterfly operand pairs.
- Each pair is presented with the stage-1 twiddles (+1, -1), so butterfly_sum produces A+B and A-B directly.

Parameters:
- N_LOG2, 3, log2 of frame length N (N = 8 by default; legal range 1..8).
- WORD_SZ, 32, packed complex word width: {real[31:16], imag[15:0]}, two's complement.
- WORD_MID, 16, component width.
- TW_ONE, 64, fixed-point 1.0 in the butterfly's twiddle format (products sliced [21:6]).

Ports:
- i_CLK  in  1  clock, rising edge.
- i_RST  in  1  reset, asynchronous, active-low.
- i_valid  in  1  upstream sample valid.
- o_ready  out  1  loader can accept a sample.
- i_sample  in  32  packed complex input sample.
- o_valid  out  1  operand pair valid.
- i_ready  in  1  downstream accepts the pair.
- o_A  out  32  butterfly operand A = mem[2k].
- o_B  out  32  butterfly operand B = mem[2k+1].
- o_twiddleA  out  32  {TW_ONE, 16'd0} while o_valid, else 0.
- o_twiddleB  out  32  {-TW_ONE, 16'd0} (0xFFC0_0000 at default) while o_valid, else 0.
- o_last  out  1  high with the final pair (k = N/2-1) of a frame.

Behaviour:
- Storage: N x 32 register array, asynchronously cleared by i_RST.
- Write counter wr_cnt is N_LOG2 bits; read counter rd_cnt is N_LOG2-1 bits.
- FSM states: FILL, DRAIN.
- Reset (i_RST = 0), immediate and asynchronous:
  - state = FILL; wr_cnt = 0; rd_cnt = 0; memory cleared.
  - Outputs: o_ready = 0, o_valid = 0, o_A = o_B = o_twiddleA = o_twiddleB = 0, o_last = 0.
  - After release: o_ready = 1 from the first clock edge onward.
- FILL:
  - o_ready = 1 and o_valid = 0.
  - On i_valid & o_ready: mem[bitrev(wr_cnt)] <= i_sample, then wr_cnt++.
  - When the accepted sample has wr_cnt = N-1: wr_cnt wraps to 0 and state becomes DRAIN on that same edge.
- DRAIN:
  - o_ready = 0; i_valid is ignored and no write occurs.
  - o_valid = 1. o_A and o_B are read combinationally from mem[2*rd_cnt] and mem[2*rd_cnt+1].
  - o_last = (rd_cnt == N/2-1).
  - On o_valid & i_ready: rd_cnt++. If the pair had o_last: rd_cnt = 0 and state becomes FILL.
  - o_ready rises the cycle after the last pair is accepted.
- Latency: the first pair is valid in the cycle after the N-th sample is accepted.
- Throughput:
  - One sample per cycle in FILL; one pair per cycle in DRAIN with i_ready held high.
  - Frame period is N + N/2 cycles; no overlap between frames.
- Backpressure: while o_valid & !i_ready, o_A, o_B, o_twiddleA, o_twiddleB and o_last hold stable.
- Gating: when o_valid = 0, o_A, o_B and both twiddles are driven to 0.
- Reset mid-frame, in either state: the partial frame is discarded and no pair is emitted.
- bitrev: reverses all N_LOG2 bits of the index. With N_LOG2 = 1 it is the identity.
- Arithmetic: no arithmetic on the data path unless the optional feature is enabled; samples are stored bit-exact.

Optional Feature:
- Macro BITREV_SCALE_EN.
- Defined: each component is arithmetically shifted right by 1 before storage: {real>>>1, imag>>>1}. This gives 1/2 input scaling against butterfly growth.
  - Example: real = -3 is stored as -2 (floor).
  - Example: imag = 0x7FFF is stored as 0x3FFF.
- Undefined: samples are stored unmodified.
- Handshake and timing are identical in both builds.

Test Plan:
1. Reset: hold i_RST = 0 for 3 cycles with i_valid = 1 -> o_ready = 0, o_valid = 0, all data outputs 0. Release -> o_ready = 1 on the next edge.
2. Bit reversal, N = 8: feed sample k = {16*k, -k} for k = 0..7 with i_ready = 1 -> four pairs (A_idx, B_idx) = (0,4), (2,6), (1,5), (3,7).
   - First pair: o_A = 0x0000_0000, o_B = 0x0040_FFFC.
   - o_last only on the 4th pair.
   - o_twiddleA = 0x0040_0000 and o_twiddleB = 0xFFC0_0000 on every valid pair.
3. Backpressure: same frame, i_ready low for 5 cycles on pair 2 -> pair (2,6) held stable with o_valid high, and o_ready stays 0. Remaining pairs are in order after i_ready rises.
4. Input stalls and wrap: drop i_valid on alternate cycles during FILL -> write order unaffected. Two back-to-back frames -> the second frame's pairs match its own data only, and o_ready rises exactly one cycle after the first frame's o_last is accepted.
5. Reset mid-operation: assert i_RST after 5 samples, then after 2 drained pairs in a second run -> no further o_valid. A fresh frame afterwards drains correctly from pair (0,4).
6. BITREV_SCALE_EN build: sample 0 = 0x7FFF_FFFD -> stored and emitted as 0x3FFF_FFFE. The non-scaled build emits 0x7FFF_FFFD.
